// File: rtl/jt6295_cmd.sv
// jt6295_cmd: queues host play/stop requests in a 4-entry FIFO and serialises
// them onto the 6295 write bus (wrn strobe + dout byte).
// Optional macro JT6295_CMD_BUSYCHK_EN: hold a popped play in WAITB while any
// of its target channels still reports busy.
module jt6295_cmd #(
   parameter int unsigned LOW_CYC  = 4,
   parameter int unsigned HIGH_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_op,
   input  logic [6:0] req_phrase,
   input  logic [3:0] req_ch,
   input  logic [3:0] req_att,
   output logic       req_ready,
   output logic       wrn,
   output logic [7:0] dout,
   input  logic [3:0] busy,
   output logic       sent
);

`ifdef JT6295_CMD_BUSYCHK_EN
   typedef enum logic [2:0] {IDLE, WAITB, LOW1, HIGH1, LOW2, HIGH2} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOW1, HIGH1, LOW2, HIGH2} state_t;
`endif

   localparam logic [3:0] LOW_LOAD  = 4'(LOW_CYC - 1);
   localparam logic [3:0] HIGH_LOAD = 4'(HIGH_CYC - 1);

   // FIFO entry layout: {op, phrase[6:0], ch[3:0], att[3:0]}
   logic [15:0] fifo_mem [4];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  count;
   logic        push, pop;
   logic [15:0] head;

   state_t      state, next_state;
   logic [3:0]  cnt, next_cnt;
   logic [15:0] cmd;
   logic        last_high;
   logic [7:0]  byte1, byte2;

   assign req_ready = (count != 3'd4);
   assign push      = req_valid & req_ready & ~rst;
   assign head      = fifo_mem[rd_ptr];

   assign byte1 = cmd[15] ? {1'b1, cmd[14:8]} : {1'b0, cmd[7:4], 3'b000};
   assign byte2 = cmd[7:0];

`ifndef JT6295_CMD_BUSYCHK_EN
   logic unused_busy;
   assign unused_busy = ^busy;
`endif

   // FIFO storage: written on every accepted request
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {req_op, req_phrase, req_ch, req_att};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         count <= count + 3'(push) - 3'(pop);
      end
   end

   // FSM state, phase counter and the command being sent
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cmd   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         if (pop) cmd <= head;
      end
   end

   // Next-state logic: each phase counts cnt down to zero, then reloads for the next
   always_comb begin
      next_state = state;
      next_cnt   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      pop        = 1'b0;
      last_high  = 1'b0;
      case (state)
         IDLE: begin
            next_cnt = cnt;
            if (count != 3'd0) begin
               pop = 1'b1;
`ifdef JT6295_CMD_BUSYCHK_EN
               if (head[15] && ((busy & head[7:4]) != 4'd0)) begin
                  next_state = WAITB;
               end else begin
                  next_state = LOW1;
                  next_cnt   = LOW_LOAD;
               end
`else
               next_state = LOW1;
               next_cnt   = LOW_LOAD;
`endif
            end
         end
`ifdef JT6295_CMD_BUSYCHK_EN
         WAITB: begin
            next_cnt = cnt;
            if ((busy & cmd[7:4]) == 4'd0) begin
               next_state = LOW1;
               next_cnt   = LOW_LOAD;
            end
         end
`endif
         LOW1: if (cnt == 4'd0) begin
            next_state = HIGH1;
            next_cnt   = HIGH_LOAD;
         end
         HIGH1: if (cnt == 4'd0) begin
            if (cmd[15]) begin
               next_state = LOW2;
               next_cnt   = LOW_LOAD;
            end else begin
               next_state = IDLE;
               last_high  = 1'b1;
            end
         end
         LOW2: if (cnt == 4'd0) begin
            next_state = HIGH2;
            next_cnt   = HIGH_LOAD;
         end
         HIGH2: if (cnt == 4'd0) begin
            next_state = IDLE;
            last_high  = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   // Registered bus outputs: one cycle behind the state, so wrn falls on the
   // second edge after a request is accepted into an empty, idle queue
   always_ff @(posedge clk) begin
      if (rst) begin
         wrn  <= 1'b1;
         dout <= 8'h00;
         sent <= 1'b0;
      end else begin
         wrn  <= !(state == LOW1 || state == LOW2);
         sent <= last_high;
         case (state)
            LOW1, HIGH1: dout <= byte1;
            LOW2, HIGH2: dout <= byte2;
            default:     dout <= dout;
         endcase
      end
   end

endmodule

// File: tb/tb_jt6295_cmd.sv
// tb_jt6295_cmd: directed checks of byte encoding, strobe timing, FIFO
// back-pressure, reset abort and (with JT6295_CMD_BUSYCHK_EN) busy waiting.
module tb_jt6295_cmd;

   localparam int unsigned LOW_CYC  = 4;
   localparam int unsigned HIGH_CYC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_op;
   logic [6:0] req_phrase;
   logic [3:0] req_ch;
   logic [3:0] req_att;
   logic       req_ready;
   logic       wrn;
   logic [7:0] dout;
   logic [3:0] busy;
   logic       sent;

   int checks   = 0;
   int failures = 0;

   jt6295_cmd #(.LOW_CYC(LOW_CYC), .HIGH_CYC(HIGH_CYC)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_phrase (req_phrase),
      .req_ch     (req_ch),
      .req_att    (req_att),
      .req_ready  (req_ready),
      .wrn        (wrn),
      .dout       (dout),
      .busy       (busy),
      .sent       (sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; blocks until the request has been accepted
   task automatic push(input bit op, input logic [6:0] ph, input logic [3:0] ch, input logic [3:0] att);
      int n = 0;
      req_valid  = 1'b1;
      req_op     = op;
      req_phrase = ph;
      req_ch     = ch;
      req_att    = att;
      while (req_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", 32'(n < 200), 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Waits for the next byte strobe and checks wait length, low/high widths,
   // dout stability and sent placement. wait_exp < 0 skips the wait-length check.
   task automatic expect_byte(input string tag, input logic [7:0] exp_d, input bit last, input int wait_exp);
      int n = 0, m = 0, bad_h = 0, bad_s = 0;
      logic [7:0] seen_d = exp_d;
      while (wrn === 1'b1 && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (wait_exp >= 0) check({tag, "_wait"}, n, wait_exp);
      else               check({tag, "_start"}, 32'(n < 60), 1);
      while (wrn === 1'b0 && m < 40) begin
         if (dout !== exp_d) seen_d = dout;
         if (sent !== 1'b0) bad_s++;
         m++;
         @(negedge clk);
      end
      check({tag, "_low"}, m, LOW_CYC);
      for (int i = 0; i < int'(HIGH_CYC); i++) begin
         if (wrn !== 1'b1) bad_h++;
         if (dout !== exp_d) seen_d = dout;
         if (sent !== (last && i == int'(HIGH_CYC) - 1)) bad_s++;
         @(negedge clk);
      end
      check({tag, "_high_bad"}, bad_h, 0);
      check({tag, "_dout"}, seen_d, exp_d);
      check({tag, "_sent_bad"}, bad_s, 0);
   endtask

   // Counts strobe-low or sent cycles over a window where the bus must stay quiet
   task automatic expect_quiet(input string tag, input int cycles);
      int act = 0;
      for (int i = 0; i < cycles; i++) begin
         if (wrn !== 1'b1 || sent !== 1'b0) act++;
         @(negedge clk);
      end
      check(tag, act, 0);
   endtask

   logic [7:0] exp_bytes [9] = '{8'h08, 8'h91, 8'h40, 8'h78, 8'hFF, 8'h8F, 8'h10, 8'hAA, 8'h15};
   bit         exp_last  [9] = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
   int         exp_wait  [9] = '{-1, 1, 0, 1, 1, 0, 1, 1, 0};

   initial begin
      rst = 1'b1; req_valid = 1'b1; req_op = 1'b1; req_phrase = 7'h05;
      req_ch = 4'b0010; req_att = 4'h3; busy = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst_wrn",   wrn, 1);
      check("rst_dout",  dout, 8'h00);
      check("rst_sent",  sent, 0);
      check("rst_ready", req_ready, 1);
      rst = 1'b0; req_valid = 1'b0;
      expect_quiet("rst_nostore", 10);

      // play phrase 5, ch 2, att 3
      push(1'b1, 7'h05, 4'b0010, 4'h3);
      expect_byte("play_b1", 8'h85, 1'b0, 2);
      expect_byte("play_b2", 8'h23, 1'b1, 0);
      expect_quiet("play_quiet", 6);

      // stop channels 1 and 4
      push(1'b0, 7'h00, 4'b1001, 4'h0);
      expect_byte("stop", 8'h48, 1'b1, 2);
      expect_quiet("stop_quiet", 6);

      // six requests back to back: the FIFO fills and the sixth is held off
      fork
         begin
            push(1'b0, 7'h00, 4'b0001, 4'h0);
            push(1'b1, 7'h11, 4'b0100, 4'h0);
            push(1'b0, 7'h00, 4'b1111, 4'h0);
            push(1'b1, 7'h7F, 4'b1000, 4'hF);
            push(1'b0, 7'h00, 4'b0010, 4'h0);
            check("fifo_full_ready", req_ready, 0);
            push(1'b1, 7'h2A, 4'b0001, 4'h5);
         end
         begin
            for (int k = 0; k < 9; k++)
               expect_byte($sformatf("seq%0d", k), exp_bytes[k], exp_last[k], exp_wait[k]);
         end
      join
      expect_quiet("seq_quiet", 6);
      check("seq_ready", req_ready, 1);

      // reset while the second byte of a play is on the bus, with a stop queued
      push(1'b1, 7'h05, 4'b0010, 4'h3);
      push(1'b0, 7'h00, 4'b1001, 4'h0);
      expect_byte("abort_b1", 8'h85, 1'b0, 1);
      check("abort_in_low2", wrn, 0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_wrn",   wrn, 1);
      check("abort_dout",  dout, 8'h00);
      check("abort_sent",  sent, 0);
      check("abort_ready", req_ready, 1);
      rst = 1'b0;
      expect_quiet("abort_fifo_empty", 30);

      // busy on the target channel
      busy = 4'b0010;
`ifdef JT6295_CMD_BUSYCHK_EN
      push(1'b1, 7'h05, 4'b0010, 4'h3);
      expect_quiet("busy_hold", 20);
      busy = 4'b0000;
      expect_byte("busy_b1", 8'h85, 1'b0, 2);
      expect_byte("busy_b2", 8'h23, 1'b1, 0);
`else
      push(1'b1, 7'h05, 4'b0010, 4'h3);
      expect_byte("busy_b1", 8'h85, 1'b0, 2);
      expect_byte("busy_b2", 8'h23, 1'b1, 0);
      busy = 4'b0000;
`endif
      expect_quiet("busy_quiet", 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
